reset_sequencer: RTL and testbench

- Sits directly downstream of the main PLL and consumes its asynchronous `locked` output.
- Runs in the PLL-generated system clock domain.
- Holds peripheral and CPU resets asserted until lock has been continuously stable for a programmable time, then releases them in sequence: peripherals first, CPU later.
- Re-asserts both resets on any loss of lock and counts lock losses seen while running.

---
 rtl/reset_sequencer.sv | 155 +++++++++++++++
 tb/tb_reset_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for a stable PLL lock, then releases peripheral and CPU resets in order.
// Optional push-button reset with debounce is compiled in with RESET_SEQ_BTN_EN.
module reset_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_CYCLES  = 1024,
    parameter int STAGE_GAP    = 16
`ifdef RESET_SEQ_BTN_EN
    ,
    parameter int BTN_DEBOUNCE = 65536
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
`ifdef RESET_SEQ_BTN_EN
    input  logic       btn_n,
`endif
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       ready,
    output logic [7:0] relock_count
);

    localparam int MAX_CYCLES = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABLE     = 2'd1,
        REL_PERIPH = 2'd2,
        RUN        = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   locked_s;
    logic                   periph_reset_q, periph_reset_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   ready_q, ready_d;
    logic [7:0]             relock_q, relock_d;
    logic                   btn_held;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];

`ifdef RESET_SEQ_BTN_EN
    localparam int BW = $clog2(BTN_DEBOUNCE + 1);

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [BW-1:0]          btn_cnt_q;
    logic                   btn_s;

    assign btn_s = btn_sync_q[SYNC_STAGES-1];

    // Counter saturates at the debounce length so a long press keeps the machine parked.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync_q <= '0;
            btn_cnt_q  <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], btn_n};
            if (btn_s) begin
                btn_cnt_q <= '0;
            end else if (btn_cnt_q != BW'(BTN_DEBOUNCE)) begin
                btn_cnt_q <= btn_cnt_q + 1'b1;
            end
        end
    end

    assign btn_held = (btn_cnt_q == BW'(BTN_DEBOUNCE));
`else
    assign btn_held = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            periph_reset_q <= 1'b1;
            cpu_reset_q    <= 1'b1;
            ready_q        <= 1'b0;
            relock_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            periph_reset_q <= periph_reset_d;
            cpu_reset_q    <= cpu_reset_d;
            ready_q        <= ready_d;
            relock_q       <= relock_d;
        end
    end

    // Lock loss is tested before the terminal count so a drop on the last cycle never releases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_CYCLES - 1)) begin
                    state_d = REL_PERIPH;
                    cnt_d   = '0;
                end
            end
            REL_PERIPH: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (!locked_s) state_d = WAIT_LOCK;
            end
        endcase
        if (btn_held) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the transition.
    always_comb begin
        periph_reset_d = !((state_d == REL_PERIPH) || (state_d == RUN));
        cpu_reset_d    = (state_d != RUN);
        ready_d        = (state_d == RUN);
        relock_d       = relock_q;
        if ((state_q == RUN) && !locked_s && (relock_q != 8'hFF)) begin
            relock_d = relock_q + 1'b1;
        end
    end

    assign periph_reset = periph_reset_q;
    assign cpu_reset    = cpu_reset_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: a lock-history model predicts outputs after every edge,
// a monitor compares them one cycle at a time.
module tb_reset_sequencer;

    localparam int SYNC  = 2;
    localparam int LOCKC = 8;
    localparam int GAP   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       periph_reset, cpu_reset, ready;
    logic [7:0] relock_count;
`ifdef RESET_SEQ_BTN_EN
    logic       btn_n = 1'b1;
`endif

    reset_sequencer #(
        .SYNC_STAGES (SYNC),
        .LOCK_CYCLES (LOCKC),
        .STAGE_GAP   (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .locked       (locked),
`ifdef RESET_SEQ_BTN_EN
        .btn_n        (btn_n),
`endif
        .periph_reset (periph_reset),
        .cpu_reset    (cpu_reset),
        .ready        (ready),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       p;
        logic       c;
        logic       r;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    bit   hist[$];
    int   high_run = 0;
    int   relock_m = 0;
    int   cyc_no   = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;

    // Model: the FSM sees `locked` SYNC edges late; outputs depend only on how many
    // consecutive edges it has seen lock high.
    task automatic model_edge(input logic rst_v, input logic lk_v);
        exp_t e;
        bit   seen;
        if (rst_v) begin
            hist.delete();
            for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
            high_run = 0;
            relock_m = 0;
        end else begin
            seen = hist.pop_front();
            hist.push_back(lk_v);
            if (seen) begin
                if (high_run < 1000000) high_run++;
            end else begin
                if (high_run >= LOCKC + GAP + 1 && relock_m < 255) relock_m++;
                high_run = 0;
            end
        end
        e.p   = (high_run < LOCKC + 1);
        e.c   = (high_run < LOCKC + GAP + 1);
        e.r   = !e.c;
        e.cnt = 8'(relock_m);
        e.cyc = cyc_no;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst_v, input logic lk_v);
        @(negedge clk);
        reset  = rst_v;
        locked = lk_v;
        cyc_no++;
        model_edge(rst_v, lk_v);
    endtask

    task automatic check1(input string name, input int cyc, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check1("periph_reset", e.cyc, int'(periph_reset), int'(e.p));
            check1("cpu_reset",    e.cyc, int'(cpu_reset),    int'(e.c));
            check1("ready",        e.cyc, int'(ready),        int'(e.r));
            check1("relock_count", e.cyc, int'(relock_count), int'(e.cnt));
        end
    end

    initial begin
        int  rl;
        bit  lk;

        // Power-up with lock tied high: release at edges 11 and 15 after reset.
        repeat (3) step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1);
        $display("phase power_up done, relock_count=%0d", relock_count);

        // Short glitch before release restarts the qualification window.
        repeat (2) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);
        $display("phase glitch done, relock_count=%0d", relock_count);

        // Lock loss from RUN, then relock with identical timing.
        repeat (3) step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);
        $display("phase relock done, relock_count=%0d", relock_count);

        // Drop on the exact terminal cycle of STABLE and of REL_PERIPH.
        repeat (2) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);
        $display("phase terminal_drop done, relock_count=%0d", relock_count);

        // 300 lock losses from RUN: counter must saturate at 255.
        for (int k = 0; k < 300; k++) begin
            repeat (14) step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        repeat (5) step(1'b0, 1'b1);
        $display("phase saturate done, relock_count=%0d", relock_count);

        // Reset while in REL_PERIPH.
        repeat (2) step(1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1);
        $display("phase reset_in_rel done, relock_count=%0d", relock_count);

        // Random lock activity with occasional resets.
        lk = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) lk = !lk;
            rl = (($urandom_range(0, 599) == 0) ? 1 : 0);
            step(rl[0], lk);
        end
        $display("phase random done, relock_count=%0d", relock_count);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
